spi_frame_ctrl: RTL and testbench

SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

---
 rtl/spi_frame_pkg.sv | 8 +
 rtl/spi_frame_buf.sv | 17 +
 rtl/spi_frame_ctrl.sv | 139 +++++++++++++
 tb/tb_spi_frame_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared state encoding, error codes and sync default for the SPI frame controller.
package spi_frame_pkg;
  typedef enum logic [2:0] {S_HUNT, S_ADDR, S_LEN, S_DATA, S_CSUM, S_COMMIT} state_t;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/spi_frame_buf.sv
// spi_frame_buf: DEPTH x 8 payload buffer, one synchronous write port, one asynchronous read port.
module spi_frame_buf #(
  parameter int DEPTH = 16,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: parses SYNC/ADDR/LEN/payload frames from an RX FIFO into register writes.
// Define SPI_FRAME_CSUM_EN to buffer the payload and commit it only after a matching XOR checksum byte.
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rd_en,
  output logic       reg_wr_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  state_t state;
  logic pend;
  logic [7:0] base, len, idx;
  logic [TW-1:0] tcnt;
  logic to_hit;
  // pend marks the cycle fifo_q carries the byte popped one cycle earlier
  assign fifo_rd_en = rst && !fifo_empty && state != S_COMMIT && !pend;
  assign to_hit = !pend && (state inside {S_ADDR, S_LEN, S_DATA, S_CSUM}) && tcnt == TW'(TIMEOUT_CYCLES - 1);
`ifdef SPI_FRAME_CSUM_EN
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  logic [7:0] csum, rd_data;
  spi_frame_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk(clk),
    .wr_en(pend && state == S_DATA),
    .wr_addr(idx[AW-1:0]),
    .wr_data(fifo_q),
    .rd_addr(idx[AW-1:0]),
    .rd_data(rd_data)
  );
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_HUNT;
      pend <= 1'b0;
      base <= '0;
      len <= '0;
      idx <= '0;
      tcnt <= '0;
      reg_wr_en <= 1'b0;
      reg_addr <= '0;
      reg_wdata <= '0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      err_code <= '0;
`ifdef SPI_FRAME_CSUM_EN
      csum <= '0;
`endif
    end else begin
      pend <= fifo_rd_en;
      reg_wr_en <= 1'b0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      tcnt <= (pend || state == S_HUNT || state == S_COMMIT) ? '0 : tcnt + TW'(1);
      if (to_hit) begin
        state <= S_HUNT;
        frame_err <= 1'b1;
        err_code <= ERR_TIMEOUT;
`ifdef SPI_FRAME_CSUM_EN
      end else if (state == S_COMMIT) begin
        if (idx == len) begin
          frame_ok <= 1'b1;
          state <= S_HUNT;
        end else begin
          reg_wr_en <= 1'b1;
          reg_addr <= base + idx;
          reg_wdata <= rd_data;
          idx <= idx + 8'd1;
        end
`endif
      end else if (pend) begin
        case (state)
          S_HUNT: state <= fifo_q == SYNC_BYTE ? S_ADDR : S_HUNT;
          S_ADDR: begin
            base <= fifo_q;
            state <= S_LEN;
`ifdef SPI_FRAME_CSUM_EN
            csum <= fifo_q;
`endif
          end
          S_LEN: begin
            if (fifo_q == 8'd0 || fifo_q > MAX_L) begin
              frame_err <= 1'b1;
              err_code <= ERR_LEN;
              state <= S_HUNT;
            end else begin
              len <= fifo_q;
              idx <= '0;
              state <= S_DATA;
            end
`ifdef SPI_FRAME_CSUM_EN
            csum <= csum ^ fifo_q;
`endif
          end
          S_DATA: begin
            idx <= idx + 8'd1;
`ifdef SPI_FRAME_CSUM_EN
            csum <= csum ^ fifo_q;
            if (idx == len - 8'd1) state <= S_CSUM;
`else
            reg_wr_en <= 1'b1;
            reg_addr <= base + idx;
            reg_wdata <= fifo_q;
            if (idx == len - 8'd1) begin
              frame_ok <= 1'b1;
              state <= S_HUNT;
            end
`endif
          end
`ifdef SPI_FRAME_CSUM_EN
          S_CSUM: begin
            if (fifo_q == csum) begin
              idx <= '0;
              state <= S_COMMIT;
            end else begin
              frame_err <= 1'b1;
              err_code <= ERR_CSUM;
              state <= S_HUNT;
            end
          end
`endif
          default: state <= S_HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed frames through a FIFO model, scoreboard of expected writes/pulses.
module tb_spi_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_q = '0;
  logic fifo_rd_en, reg_wr_en, frame_ok, frame_err;
  logic [7:0] reg_addr, reg_wdata;
  logic [1:0] err_code;
  typedef struct packed {logic [1:0] kind; logic [7:0] a; logic [7:0] d;} ev_t;
  logic [7:0] fq[$];
  ev_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  spi_frame_ctrl #(.TIMEOUT_CYCLES(40)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_q(fifo_q),
    .fifo_rd_en(fifo_rd_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (fifo_rd_en) begin
      if (fq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL pop_empty: rd_en with empty fifo at %0t", $time);
      end else fifo_q <= fq.pop_front();
    end
  always @(negedge clk) fifo_empty <= (fq.size() == 0);

  task automatic chk_ev(input ev_t got, input string nm);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected: got kind=%0d a=%h d=%h, required nothing", nm, got.kind, got.a, got.d);
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d a=%h d=%h, required kind=%0d a=%h d=%h",
                 nm, got.kind, got.a, got.d, e.kind, e.a, e.d);
      end
    end
  endtask

  always @(negedge clk)
    if (rst) begin
      if (reg_wr_en) chk_ev({2'd0, reg_addr, reg_wdata}, "write");
      if (frame_ok) chk_ev({2'd1, 8'h00, 8'h00}, "frame_ok");
      if (frame_err) chk_ev({2'd2, 8'h00, {6'b0, err_code}}, "frame_err");
    end

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] l,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] cs);
    logic [7:0] d[3];
    logic [7:0] x;
    d = '{d0, d1, d2};
    x = a ^ l;
    push(8'hA5);
    push(a);
    push(l);
    for (int i = 0; i < int'(l); i++) begin
      push(d[i]);
      x = x ^ d[i];
    end
`ifdef SPI_FRAME_CSUM_EN
    push(cs);
    if (cs == x) begin
      for (int i = 0; i < int'(l); i++) exp_q.push_back({2'd0, a + 8'(i), d[i]});
      exp_q.push_back({2'd1, 8'h00, 8'h00});
    end else exp_q.push_back({2'd2, 8'h00, 8'h02});
`else
    if (cs != x) $display("note: checksum byte %h not sent in this build", cs);
    for (int i = 0; i < int'(l); i++) exp_q.push_back({2'd0, a + 8'(i), d[i]});
    exp_q.push_back({2'd1, 8'h00, 8'h00});
`endif
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fq.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    n_chk++;
    if (n >= 2000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d events still expected, %0d bytes queued after %0d cycles",
               exp_q.size(), fq.size(), n);
    end
  endtask

  task automatic chk_idle(input string nm);
    n_chk++;
    if ({fifo_rd_en, reg_wr_en, frame_ok, frame_err, reg_addr, reg_wdata, err_code} != '0) begin
      n_fail++;
      $display("FAIL %s: outputs rd=%b wr=%b ok=%b err=%b addr=%h data=%h code=%0d, required all 0",
               nm, fifo_rd_en, reg_wr_en, frame_ok, frame_err, reg_addr, reg_wdata, err_code);
    end
  endtask

  task automatic chk_code(input logic [1:0] want, input string nm);
    n_chk++;
    if (err_code != want) begin
      n_fail++;
      $display("FAIL %s: err_code=%0d, required %0d", nm, err_code, want);
    end
  endtask

  initial begin
    push(8'hA5);
    repeat (3) @(posedge clk);
    #1 chk_idle("reset_state");
    fq.delete();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    frame(8'h10, 8'd2, 8'h11, 8'h22, 8'h00, 8'h21);
    wait_done();
    chk_code(2'd0, "err_code_after_ok");
    frame(8'h10, 8'd2, 8'h11, 8'h22, 8'h00, 8'h00);
    wait_done();
    push(8'h00); push(8'hFF); push(8'hA5); push(8'h20); push(8'h00);
    exp_q.push_back({2'd2, 8'h00, 8'h01});
    wait_done();
    chk_code(2'd1, "err_code_len");
    frame(8'hFE, 8'd3, 8'hAA, 8'hBB, 8'hCC, 8'h20);
    wait_done();
    chk_code(2'd1, "err_code_held");
    push(8'hA5); push(8'h10);
    exp_q.push_back({2'd2, 8'h00, 8'h03});
    wait_done();
    chk_code(2'd3, "err_code_timeout");
    frame(8'h10, 8'd2, 8'h11, 8'h22, 8'h00, 8'h21);
    wait_done();
    push(8'hA5); push(8'h10); push(8'h02); push(8'hA5);
`ifndef SPI_FRAME_CSUM_EN
    exp_q.push_back({2'd0, 8'h10, 8'hA5});
`endif
    wait_done();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 chk_idle("mid_frame_reset");
    rst = 1'b1;
    frame(8'h30, 8'd1, 8'h5A, 8'h00, 8'h00, 8'h6B);
    wait_done();
    chk_code(2'd0, "err_code_after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
